// File: rtl/scoreboard_reg_file.sv
// scoreboard_reg_file: register file with per-register pending-write counters for in-order issue scoreboarding
module scoreboard_reg_file #(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 32,
    parameter int CNT_W = 2,
    localparam int IDX_W = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx1,
    input  logic [IDX_W-1:0]  rd_idx2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              rsv_en,
    input  logic [IDX_W-1:0]  rsv_idx,
    output logic              rsv_ack,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy_any,
    output logic              err_wb
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busyVec;
    logic wbLive;

    assign wbLive = wb_en && wb_idx != '0;
    assign rsv_ack = rsv_en && (rsv_idx == '0 || cnt[rsv_idx] != '1);
    assign busy_any = |busyVec;

    assign rd_data1 = (wbLive && wb_idx == rd_idx1) ? wb_data : regs[rd_idx1];
    assign rd_data2 = (wbLive && wb_idx == rd_idx2) ? wb_data : regs[rd_idx2];
    // A last pending write landing this cycle is visible through the bypass, so the operand is ready.
    assign rd_ready1 = rd_idx1 == '0 || cnt[rd_idx1] == '0
                       || (cnt[rd_idx1] == CNT_W'(1) && wbLive && wb_idx == rd_idx1);
    assign rd_ready2 = rd_idx2 == '0 || cnt[rd_idx2] == '0
                       || (cnt[rd_idx2] == CNT_W'(1) && wbLive && wb_idx == rd_idx2);

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : gen_reg
        logic inc, dec, hit;
        assign hit = g != 0 && wb_en && wb_idx == IDX_W'(g);
        assign inc = g != 0 && rsv_ack && rsv_idx == IDX_W'(g);
        assign dec = hit && cnt[g] != '0;
        assign busyVec[g] = cnt[g] != '0;
        always_ff @(posedge clk) begin
            if (!reset) begin
                regs[g] <= '0;
                cnt[g] <= '0;
            end else begin
                if (hit) regs[g] <= wb_data;
                cnt[g] <= cnt[g] + CNT_W'(inc) - CNT_W'(dec);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) err_wb <= 1'b0;
        else err_wb <= wbLive && cnt[wb_idx] == '0;
    end
endmodule

// File: doc/scoreboard_reg_file.md
SCOREBOARD_REG_FILE -- requirements
Module: scoreboard_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, register count; power of two, at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 2, width of each per-register pending counter; MAX = 2^CNT_W-1.
REQ-004 The block SHALL derive IDX_W = clog2(NUM_REGS); it is not user-settable.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have ports rd_idx1 and rd_idx2, input, IDX_W bits each: read-port register indices.
REQ-008 The block SHALL have ports rd_data1 and rd_data2, output, DATA_W bits each: combinational read data.
REQ-009 The block SHALL have ports rd_ready1 and rd_ready2, output, 1 bit each: 1 means the operand holds no outstanding write.
REQ-010 The block SHALL have port rsv_en, input, 1 bit: issue stage requests a destination reservation.
REQ-011 The block SHALL have port rsv_idx, input, IDX_W bits: destination index to reserve.
REQ-012 The block SHALL have port rsv_ack, output, 1 bit: combinational; reservation accepted this cycle.
REQ-013 The block SHALL have ports wb_en (input, 1 bit), wb_idx (input, IDX_W bits) and wb_data (input, DATA_W bits): write-back port.
REQ-014 The block SHALL have port busy_any, output, 1 bit: combinational; 1 when any pending counter is nonzero.
REQ-015 The block SHALL have port err_wb, output, 1 bit: registered; one-cycle pulse on a write-back to a register with no pending reservation.

Function
REQ-016 Register 0 SHALL read as 0 at all times, ignore writes, always report ready, and never change its counter.
REQ-017 The read path SHALL behave as follows: if wb_en=1, wb_idx=rd_idxN and rd_idxN!=0, rd_dataN SHALL equal wb_data (same-cycle bypass); otherwise rd_dataN SHALL equal the stored register.
REQ-018 For a nonzero index, rd_readyN SHALL be 1 if its counter is 0, or if its counter is 1 and a write-back to that index occurs this cycle; otherwise it SHALL be 0.
REQ-019 rsv_ack SHALL equal rsv_en AND (rsv_idx=0 OR counter[rsv_idx]<MAX); a saturated counter SHALL refuse the reservation and the issue stage stalls.
REQ-020 On a clock edge with wb_en=1 and wb_idx!=0, the register SHALL be written with wb_data, regardless of counter value.
REQ-021 The next counter value SHALL be counter + inc - dec, where inc = accepted reservation to this index and dec = write-back to this index while counter>0.
REQ-022 A simultaneous accepted reservation and write-back to the same index SHALL leave the counter unchanged and write the data.
REQ-023 A write-back with wb_idx!=0 to a register whose counter is 0 SHALL write the data, leave the counter at 0, and set err_wb=1 on the next cycle only.
REQ-024 Counters SHALL never wrap: there SHALL be no increment past MAX and no decrement below 0.
REQ-025 Read ports SHALL be independent; both may address the same index, including the index being written back.

Reset
REQ-026 While reset=0 at a rising edge, all registers SHALL clear to 0, all counters to 0, and err_wb to 0; reset SHALL dominate simultaneous rsv_en and wb_en.
REQ-027 After reset, rd_data* SHALL be 0, rd_ready* SHALL be 1, and busy_any SHALL be 0; rsv_ack SHALL still follow REQ-019 combinationally.
REQ-028 A reset asserted mid-operation SHALL discard all outstanding reservations without raising err_wb on later write-backs of stale results, provided those write-backs land while reset=0.

Verification
REQ-029 The bench SHALL cover: reserve r5, next cycle read r5 -> rd_ready1=0; wb r5=0x1234 -> same cycle rd_data1=0x1234 and rd_ready1=1; next cycle rd_ready1=1 from storage.
REQ-030 The bench SHALL cover (CNT_W=2): reserve r7 three times -> rsv_ack=1 each time; fourth reservation -> rsv_ack=0 and counter stays 3; three write-backs -> ready after the third.
REQ-031 The bench SHALL cover: wb r9=0xAA with counter 0 -> r9 reads 0xAA next cycle, err_wb=1 for exactly one cycle, counter 0.
REQ-032 The bench SHALL cover: same-cycle reserve and wb r3 with counter 1 -> counter stays 1, r3=wb_data, rd_ready=0.
REQ-033 The bench SHALL cover: reserve and wb r0 with data 0xFFFF -> rsv_ack=1, rd_data=0, rd_ready=1, busy_any=0, err_wb=0.
REQ-034 The bench SHALL cover: reserve r4 and r6, then reset=0 for one edge -> all registers 0, busy_any=0, rd_ready=1 on every index.
